kbd_fifo_ctrl: RTL and testbench

//  Memory-mapped receive-queue controller for the PS/2 keyboard. It accepts framed bytes from the PS/2 receiver on

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/kbd_queue_ram.sv | 16 +
 rtl/kbd_fifo_ctrl.sv | 67 ++++++
 tb/tb_kbd_fifo_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared addresses, sizes, status layout and handshake states for the keyboard queue.
package kbd_pkg;
  localparam int DEPTH = 64;
  localparam int PTR_W = 6;
  localparam logic [13:0] DATA_ADDR = 14'h3fff;
  localparam logic [13:0] STATUS_ADDR = 14'h3ffe;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam int ST_FRAME_ERR = 15;
  localparam int ST_OVERFLOW = 14;
  localparam int ST_FULL = 13;
  localparam int ST_EMPTY = 12;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP = 2'd1,
    HOLD = 2'd2
  } state_e;
  function automatic logic [63:0] status_word(logic ferr, logic ovf, logic [PTR_W:0] cnt);
    logic [63:0] w;
    w = '0;
    w[ST_FRAME_ERR] = ferr;
    w[ST_OVERFLOW] = ovf;
    w[ST_FULL] = cnt == CNT_FULL;
    w[ST_EMPTY] = cnt == '0;
    w[PTR_W:0] = cnt;
    return w;
  endfunction
endpackage

// File: rtl/kbd_queue_ram.sv
// kbd_queue_ram: DEPTH x 8 register file, one synchronous write port, one asynchronous read port.
module kbd_queue_ram
  import kbd_pkg::*;
(
  input  logic             system_clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge system_clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/kbd_fifo_ctrl.sv
// kbd_fifo_ctrl: PS/2 receive queue with memory-mapped DATA/STATUS access and one pop per CPU strobe.
module kbd_fifo_ctrl
  import kbd_pkg::*;
(
  input  logic        system_clk,
  input  logic        reset,
  input  logic [13:0] address,
  input  logic        read_strobe,
  output logic [63:0] data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  output logic        irq
);
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d, frame_err_q, frame_err_d, irq_q, irq_d;
  state_e           state_q, state_d;
  logic             is_data, is_status, pop, push, clr;
  logic [7:0]       head;
  kbd_queue_ram u_ram (
    .system_clk(system_clk),
    .we        (push),
    .waddr     (wr_ptr_q),
    .wdata     (rx_byte),
    .raddr     (rd_ptr_q),
    .rdata     (head)
  );
  always_comb begin
    is_data = address == DATA_ADDR;
    is_status = address == STATUS_ADDR;
    pop = state_q == POP && count_q != '0;
    // a pop in the same cycle frees the slot, so a full queue still accepts the byte
    push = rx_valid && (count_q != CNT_FULL || pop);
    clr = state_q == IDLE && read_strobe && is_status;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d = (push && !pop) ? count_q + (PTR_W+1)'(1) :
              (pop && !push) ? count_q - (PTR_W+1)'(1) : count_q;
    overflow_d = (rx_valid && !push) || (overflow_q && !clr);
    frame_err_d = rx_error || (frame_err_q && !clr);
    irq_d = count_d != '0;
    state_d = state_q == IDLE ? (read_strobe && is_data ? POP : read_strobe && is_status ? HOLD : IDLE) :
              state_q == POP ? HOLD : (read_strobe ? HOLD : IDLE);
    data = is_data ? {56'b0, count_q != '0 ? head : 8'h00} :
           is_status ? status_word(frame_err_q, overflow_q, count_q) : 64'b0;
  end
  always_ff @(posedge system_clk or negedge reset)
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      frame_err_q <= frame_err_d;
      irq_q <= irq_d;
      state_q <= state_d;
    end
  assign irq = irq_q;
endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// tb_kbd_fifo_ctrl: scoreboard bench; stimulus tasks queue expectations from a byte-queue model, a negedge monitor checks them.
module tb_kbd_fifo_ctrl;
  localparam logic [13:0] DA = 14'h3fff;
  localparam logic [13:0] SA = 14'h3ffe;
  logic        system_clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] address = '0;
  logic        read_strobe = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [63:0] data;
  logic        irq;
  kbd_fifo_ctrl dut (
    .system_clk (system_clk),
    .reset      (reset),
    .address    (address),
    .read_strobe(read_strobe),
    .data       (data),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .irq        (irq)
  );
  always #5 system_clk = ~system_clk;
  typedef struct {
    logic [63:0] v;
    bit          is_irq;
    string       nm;
  } exp_t;
  exp_t exp_q[$];
  byte unsigned mq[$];
  bit ovf, ferr;
  int nsamp, total, bad;
  function automatic logic [63:0] stat();
    return {48'b0, ferr, ovf, mq.size() == 64, mq.size() == 0, 5'b0, 7'(mq.size())};
  endfunction
  function automatic logic [63:0] head();
    return mq.size() != 0 ? {56'b0, mq[0]} : 64'b0;
  endfunction
  task automatic tick();
    @(posedge system_clk);
    #1;
    nsamp = 0;
  endtask
  task automatic expect_v(logic [63:0] v, bit is_irq, string nm);
    exp_t e;
    e.v = v;
    e.is_irq = is_irq;
    e.nm = nm;
    exp_q.push_back(e);
    nsamp++;
  endtask
  task automatic model_push(byte unsigned b);
    if (mq.size() < 64) mq.push_back(b);
    else ovf = 1;
  endtask
  task automatic push(byte unsigned b);
    rx_valid = 1;
    rx_byte = b;
    tick();
    rx_valid = 0;
    model_push(b);
  endtask
  task automatic err();
    rx_error = 1;
    tick();
    rx_error = 0;
    ferr = 1;
  endtask
  task automatic peek(logic [13:0] a, string nm);
    address = a;
    read_strobe = 0;
    expect_v(a == SA ? stat() : head(), 0, nm);
    expect_v({63'b0, mq.size() != 0}, 1, {nm, "_irq"});
    tick();
  endtask
  task automatic read_data(int n, bit pp, byte unsigned pb, string nm);
    address = DA;
    read_strobe = 1;
    expect_v(head(), 0, nm);
    tick();
    if (pp) begin
      rx_valid = 1;
      rx_byte = pb;
    end
    if (n < 2) read_strobe = 0;
    tick();
    rx_valid = 0;
    if (mq.size() != 0) void'(mq.pop_front());
    if (pp) model_push(pb);
    for (int i = 2; i < n; i++) tick();
    read_strobe = 0;
    tick();
    tick();
  endtask
  task automatic read_status(int n, bit e, string nm);
    address = SA;
    read_strobe = 1;
    expect_v(stat(), 0, nm);
    if (e) rx_error = 1;
    tick();
    rx_error = 0;
    ovf = 0;
    ferr = e;
    for (int i = 1; i < n; i++) tick();
    read_strobe = 0;
    tick();
    tick();
  endtask
  always @(negedge system_clk) begin
    for (int i = 0; i < nsamp; i++) begin
      exp_t e;
      logic [63:0] act;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underrun: sample with no expectation");
      end else begin
        e = exp_q.pop_front();
        act = e.is_irq ? {63'b0, irq} : data;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
        end
      end
    end
  end
  initial begin
    repeat (3) tick();
    peek(SA, "rst_status_held");
    reset = 1;
    tick();
    peek(SA, "rst_status");
    peek(DA, "rst_data");
    push(8'h1C);
    push(8'h32);
    peek(SA, "t1_status");
    read_data(5, 0, 0, "t1_first");
    peek(SA, "t1_after_pop");
    read_data(1, 0, 0, "t1_second");
    for (int i = 0; i < 64; i++) push(8'(i));
    push(8'hAA);
    peek(SA, "t2_full");
    for (int i = 0; i < 64; i++) read_data(1 + int'($urandom_range(0, 2)), 0, 0, "t2_drain");
    peek(SA, "t2_empty");
    peek(DA, "t2_data_zero");
    read_status(1, 0, "t3_clear");
    for (int i = 0; i < 64; i++) push(8'($urandom));
    read_data(2, 1, 8'h55, "t3_push_pop");
    peek(SA, "t3_status");
    for (int i = 0; i < 64; i++) read_data(1, 0, 0, "t3_drain");
    peek(SA, "t3_empty");
    read_data(1, 1, 8'h29, "t4_empty_strobe");
    peek(SA, "t4_status");
    peek(DA, "t4_data");
    read_data(3, 0, 0, "t4_pop");
    err();
    peek(SA, "t5_ferr_set");
    read_status(2, 0, "t5_clear");
    peek(SA, "t5_cleared");
    err();
    read_status(1, 1, "t5_race");
    peek(SA, "t5_race_kept");
    read_status(4, 0, "t5_final_clear");
    for (int i = 0; i < 6; i++) push(8'($urandom));
    err();
    address = DA;
    read_strobe = 1;
    expect_v(head(), 0, "t6_head");
    tick();
    tick();
    void'(mq.pop_front());
    tick();
    reset = 0;
    #1;
    mq.delete();
    ovf = 0;
    ferr = 0;
    expect_v(64'b0, 0, "t6_rst_data");
    expect_v(64'b0, 1, "t6_rst_irq");
    tick();
    tick();
    reset = 1;
    repeat (3) tick();
    read_strobe = 0;
    tick();
    tick();
    peek(SA, "t6_after_release");
    for (int it = 0; it < 700; it++) begin
      int r, pw;
      r = int'($urandom_range(0, 99));
      pw = (it % 200) < 110 ? 75 : 25;
      if (r < pw) push(8'($urandom));
      else if (r < pw + 4) err();
      else if (r < 90) read_data(1 + int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 8'($urandom), "rnd_data");
      else if (r < 95) read_status(1 + int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, "rnd_status");
      else peek($urandom_range(0, 1) ? SA : DA, "rnd_peek");
    end
    peek(SA, "final_status");
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d expectations never sampled, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
